// File: rtl/fp_pkg.sv
// Shared FP32 field definitions for the adder front end and the post-normalisation stage.
package fp_pkg;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned GRS_W = 3;
  localparam int unsigned SIG_W = 1 + MAN_W + GRS_W;
  localparam int unsigned FP_W  = 1 + EXP_W + MAN_W;

  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  typedef struct packed {
    logic             sign;
    logic             op_implied;
    logic [EXP_W-1:0] exp_a;
    logic [EXP_W-1:0] exp_b;
    logic [MAN_W-1:0] man_a;
    logic [MAN_W-1:0] man_b;
    logic [EXP_W-1:0] diff;
  } align_s1_t;

  typedef struct packed {
    logic             sign;
    logic             op_implied;
    logic             denorm_a;
    logic             denorm_b;
    logic [EXP_W-1:0] exp_a;
    logic [EXP_W-1:0] exp_b;
    logic [MAN_W-1:0] man_a;
    logic [MAN_W-1:0] man_b;
    logic [SIG_W-1:0] sig_a;
    logic [SIG_W-1:0] sig_b;
  } align_out_t;

  function automatic logic fp_sign(input logic [FP_W-1:0] x);
    return x[FP_W-1];
  endfunction

  function automatic logic [EXP_W-1:0] fp_exp(input logic [FP_W-1:0] x);
    return x[FP_W-2 -: EXP_W];
  endfunction

  function automatic logic [MAN_W-1:0] fp_man(input logic [FP_W-1:0] x);
    return x[MAN_W-1:0];
  endfunction

  function automatic logic [FP_W-2:0] fp_mag(input logic [FP_W-1:0] x);
    return x[FP_W-2:0];
  endfunction

  // Denormals share the exponent of exp==1.
  function automatic logic [EXP_W-1:0] fp_eff_exp(input logic [EXP_W-1:0] e);
    return (e == '0) ? EXP_W'(1) : e;
  endfunction

endpackage

// File: rtl/fp_align_shifter.sv
// Combinational logical right shifter; every bit shifted out is ORed into the result LSB.
module fp_align_shifter
  import fp_pkg::*;
#(
  parameter int unsigned WIDTH = SIG_W,
  parameter int unsigned AMT_W = EXP_W
) (
  input  logic [WIDTH-1:0] i_sig,
  input  logic [AMT_W-1:0] i_amt,
  output logic [WIDTH-1:0] o_sig
);

  logic [WIDTH-1:0] w_mask;
  logic             w_sticky;

  // Shifts of WIDTH or more yield zero and a full mask, so saturation needs no special case.
  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_mask[i] = (i < 32'(i_amt));
    end
    w_sticky = |(i_sig & w_mask);
    o_sig    = (i_sig >> i_amt) | WIDTH'(w_sticky);
  end

endmodule

// File: rtl/fp_add_align.sv
// FP32 adder front end: operand swap, effective op/sign, and significand alignment in a 2-stage valid/ready pipe.
module fp_add_align
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  in_a,
  input  logic [FP_W-1:0]  in_b,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign,
  output logic             op_implied,
  output logic             denormalA,
  output logic             denormalB,
  output logic [EXP_W-1:0] expA,
  output logic [EXP_W-1:0] expB,
  output logic [MAN_W-1:0] manA,
  output logic [MAN_W-1:0] manB,
  output logic [SIG_W-1:0] sig_a,
  output logic [SIG_W-1:0] sig_b
);

  logic       r_s1_valid;
  align_s1_t  r_s1;
  logic       r_out_valid;
  align_out_t r_out;

  logic       w_sign_b;
  logic       w_swap;
  logic       w_eq;
  logic       w_op_implied;
  logic       w_s2_adv;
  logic       w_s1_load;
  align_s1_t  w_s1_next;
  align_out_t w_out_next;
  logic [SIG_W-1:0] w_sig_b_raw;
  logic [SIG_W-1:0] w_sig_b_aligned;

  assign w_sign_b     = fp_sign(in_b) ^ in_op;
  assign w_op_implied = fp_sign(in_a) ^ w_sign_b;
  assign w_swap       = fp_mag(in_b) > fp_mag(in_a);
  assign w_eq         = fp_mag(in_b) == fp_mag(in_a);

  always_comb begin
    w_s1_next            = '0;
    w_s1_next.op_implied = w_op_implied;
    w_s1_next.exp_a      = w_swap ? fp_exp(in_b) : fp_exp(in_a);
    w_s1_next.exp_b      = w_swap ? fp_exp(in_a) : fp_exp(in_b);
    w_s1_next.man_a      = w_swap ? fp_man(in_b) : fp_man(in_a);
    w_s1_next.man_b      = w_swap ? fp_man(in_a) : fp_man(in_b);
    w_s1_next.diff       = fp_eff_exp(w_s1_next.exp_a) - fp_eff_exp(w_s1_next.exp_b);
    // Exact cancellation rounds to +0; otherwise the larger operand's sign wins.
    if (w_op_implied && w_eq) begin
      w_s1_next.sign = 1'b0;
    end else begin
      w_s1_next.sign = w_swap ? w_sign_b : fp_sign(in_a);
    end
  end

  assign w_sig_b_raw = {|r_s1.exp_b, r_s1.man_b, GRS_W'(0)};

  fp_align_shifter #(
    .WIDTH (SIG_W),
    .AMT_W (EXP_W)
  ) u_shifter (
    .i_sig (w_sig_b_raw),
    .i_amt (r_s1.diff),
    .o_sig (w_sig_b_aligned)
  );

  always_comb begin
    w_out_next            = '0;
    w_out_next.sign       = r_s1.sign;
    w_out_next.op_implied = r_s1.op_implied;
    w_out_next.denorm_a   = (r_s1.exp_a == '0);
    w_out_next.denorm_b   = (r_s1.exp_b == '0);
    w_out_next.exp_a      = r_s1.exp_a;
    w_out_next.exp_b      = r_s1.exp_b;
    w_out_next.man_a      = r_s1.man_a;
    w_out_next.man_b      = r_s1.man_b;
    w_out_next.sig_a      = {|r_s1.exp_a, r_s1.man_a, GRS_W'(0)};
    w_out_next.sig_b      = w_sig_b_aligned;
  end

  assign w_s2_adv  = ~r_out_valid | out_ready;
  assign in_ready  = ~r_s1_valid | w_s2_adv;
  assign w_s1_load = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1        <= '0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
      end
      if (w_s1_load) begin
        r_s1 <= w_s1_next;
      end
      if (w_s2_adv) begin
        r_out_valid <= r_s1_valid;
      end
      if (w_s2_adv && r_s1_valid) begin
        r_out <= w_out_next;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign sign       = r_out.sign;
  assign op_implied = r_out.op_implied;
  assign denormalA  = r_out.denorm_a;
  assign denormalB  = r_out.denorm_b;
  assign expA       = r_out.exp_a;
  assign expB       = r_out.exp_b;
  assign manA       = r_out.man_a;
  assign manB       = r_out.man_b;
  assign sig_a      = r_out.sig_a;
  assign sig_b      = r_out.sig_b;

endmodule

// File: tb/tb_fp_add_align.sv
// Directed and randomized bench for fp_add_align against an arithmetic reference model.
module tb_fp_add_align;
  import fp_pkg::*;

  typedef struct packed {
    logic        sign;
    logic        opi;
    logic        dA;
    logic        dB;
    logic [7:0]  eA;
    logic [7:0]  eB;
    logic [22:0] mA;
    logic [22:0] mB;
    logic [26:0] sa;
    logic [26:0] sb;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_op;
  logic [31:0] in_a, in_b;
  logic        out_valid, out_ready;
  logic        sign, op_implied, denormalA, denormalB;
  logic [7:0]  expA, expB;
  logic [22:0] manA, manB;
  logic [26:0] sig_a, sig_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_add_align dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sign       (sign),
    .op_implied (op_implied),
    .denormalA  (denormalA),
    .denormalB  (denormalB),
    .expA       (expA),
    .expB       (expB),
    .manA       (manA),
    .manB       (manB),
    .sig_a      (sig_a),
    .sig_b      (sig_b)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t get_out();
    return '{sign, op_implied, denormalA, denormalB, expA, expB, manA, manB, sig_a, sig_b};
  endfunction

  // Reference: magnitudes compared as integers, alignment by integer divide/remainder.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic op);
    res_t r;
    logic sb_eff, swap;
    logic [31:0] x, y;
    int ex, ey, diff;
    longint unsigned sx, sy, q, den;
    bit st;
    sb_eff = b[31] ^ op;
    r.opi  = a[31] ^ sb_eff;
    swap   = b[30:0] > a[30:0];
    x      = swap ? b : a;
    y      = swap ? a : b;
    r.sign = (r.opi && a[30:0] == b[30:0]) ? 1'b0 : (swap ? sb_eff : a[31]);
    r.eA = x[30:23];
    r.eB = y[30:23];
    r.mA = x[22:0];
    r.mB = y[22:0];
    r.dA = (x[30:23] == 8'd0);
    r.dB = (y[30:23] == 8'd0);
    ex = r.dA ? 1 : int'(x[30:23]);
    ey = r.dB ? 1 : int'(y[30:23]);
    diff = ex - ey;
    sx = ((r.dA ? 64'd0 : 64'd8388608) + 64'(x[22:0])) * 64'd8;
    sy = ((r.dB ? 64'd0 : 64'd8388608) + 64'(y[22:0])) * 64'd8;
    if (diff >= 40) begin
      q  = 64'd0;
      st = (sy != 64'd0);
    end else begin
      den = 64'd1 << diff;
      q   = sy / den;
      st  = (sy % den) != 64'd0;
    end
    r.sa = 27'(sx);
    r.sb = 27'(q) | 27'(st);
    return r;
  endfunction

  // Alignment results are don't-care when either operand is Inf/NaN.
  function automatic res_t mask_special(input res_t r);
    res_t m = r;
    if (r.eA == EXP_MAX || r.eB == EXP_MAX) begin
      m.sa = '0;
      m.sb = '0;
    end
    return m;
  endfunction

  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic op, output res_t got);
    bit acc = 0, done = 0;
    got = '0;
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 20 && !acc; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("accept_timeout", acc, 1'b1);
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (out_valid) begin
        got  = get_out();
        done = 1;
      end
      @(posedge clk); #1;
    end
    chk("result_timeout", done, 1'b1);
  endtask

  function automatic logic [31:0] gen_a();
    logic [31:0] a = $urandom;
    if ($urandom_range(0, 7) == 0) a[30:23] = 8'd0;
    return a;
  endfunction

  function automatic logic [31:0] gen_b(input logic [31:0] a);
    logic [31:0] b = $urandom;
    int e;
    case ($urandom_range(0, 5))
      0: b = a;
      1: b = {~a[31], a[30:0]};
      2, 3: begin
        e = int'(a[30:23]) + int'($urandom_range(0, 60)) - 30;
        if (e < 0) e = 0;
        if (e > 254) e = 254;
        b[30:23] = 8'(e);
      end
      default: ;
    endcase
    return b;
  endfunction

  res_t got, snap, e0, e1, e2;
  res_t sbq[$];
  logic [31:0] ops_a[3], ops_b[3];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_data", get_out(), 120'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    run_one(32'h3F800000, 32'h3F000000, 1'b0, got);
    chk("t1_expA", got.eA, 8'h7F);
    chk("t1_expB", got.eB, 8'h7E);
    chk("t1_sig_a", got.sa, 27'h4000000);
    chk("t1_sig_b", got.sb, 27'h2000000);
    chk("t1_opi_sign", {got.opi, got.sign}, 2'b00);

    run_one(32'h3F000000, 32'hBF800000, 1'b0, got);
    chk("t2_expA", got.eA, 8'h7F);
    chk("t2_opi_sign", {got.opi, got.sign}, 2'b11);
    chk("t2_sigs", {got.sa, got.sb}, {27'h4000000, 27'h2000000});

    run_one(32'h4B800000, 32'h3F800001, 1'b0, got);
    chk("t3_diff24_sig_b", got.sb, 27'h0000005);
    run_one(32'h4F800000, 32'h3F800000, 1'b0, got);
    chk("t3_diff32_sig_b", got.sb, 27'h0000001);

    run_one(32'h00000001, 32'h00800000, 1'b0, got);
    chk("t4_expA", got.eA, 8'h01);
    chk("t4_denorm", {got.dA, got.dB}, 2'b01);
    chk("t4_sigs", {got.sa, got.sb}, {27'h4000000, 27'h0000008});
    run_one(32'h40400000, 32'h40400000, 1'b1, got);
    chk("t4_cancel", {got.opi, got.sign}, 2'b10);
    run_one(32'h80000000, 32'h80000000, 1'b0, got);
    chk("negzero_sum", {got.opi, got.sign}, 2'b01);

    // Backpressure: two ops fill the pipe, the third is refused until release.
    for (int i = 0; i < 3; i++) begin
      ops_a[i] = gen_a();
      ops_b[i] = gen_b(ops_a[i]);
    end
    e0 = mask_special(model(ops_a[0], ops_b[0], 1'b0));
    e1 = mask_special(model(ops_a[1], ops_b[1], 1'b1));
    e2 = mask_special(model(ops_a[2], ops_b[2], 1'b0));
    out_ready = 1'b0; in_valid = 1'b1;
    in_a = ops_a[0]; in_b = ops_b[0]; in_op = 1'b0;
    @(negedge clk); chk("t5_ready0", in_ready, 1'b1);
    @(posedge clk); #1 in_a = ops_a[1]; in_b = ops_b[1]; in_op = 1'b1;
    @(negedge clk); chk("t5_ready1", in_ready, 1'b1);
    @(posedge clk); #1 in_a = ops_a[2]; in_b = ops_b[2]; in_op = 1'b0;
    @(negedge clk);
    chk("t5_ready2_blocked", in_ready, 1'b0);
    chk("t5_out_valid", out_valid, 1'b1);
    snap = get_out();
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_stall_stable", get_out(), snap);
    chk("t5_still_blocked", in_ready, 1'b0);
    @(posedge clk); #1 out_ready = 1'b1;
    begin
      int n = 0;
      for (int c = 0; c < 20 && n < 3; c++) begin
        bit acc;
        @(negedge clk);
        if (out_valid) begin
          case (n)
            0: chk("t5_res0", mask_special(get_out()), e0);
            1: chk("t5_res1", mask_special(get_out()), e1);
            default: chk("t5_res2", mask_special(get_out()), e2);
          endcase
          n++;
        end
        acc = in_valid && in_ready;
        @(posedge clk); #1;
        if (acc) in_valid = 1'b0;
      end
      chk("t5_count", n, 3);
    end

    // Random stream with random backpressure and one mid-stream reset.
    begin
      int sent = 0;
      bit did_rst = 0;
      bit first_post_chk = 0;
      res_t first_post;
      in_valid = 1'b0;
      for (int c = 0; c < 60000 && (sent < 10000 || sbq.size() != 0); c++) begin
        bit acc;
        @(negedge clk);
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            chk("rand_unexpected_output", 1'b1, 1'b0);
          end else begin
            if (did_rst && !first_post_chk) begin
              first_post_chk = 1;
              chk("post_reset_first", mask_special(get_out()), first_post);
            end
            chk("rand_result", mask_special(get_out()), sbq.pop_front());
          end
        end
        acc = in_valid && in_ready;
        if (acc) begin
          if (did_rst && sbq.size() == 0 && !first_post_chk)
            first_post = mask_special(model(in_a, in_b, in_op));
          sbq.push_back(mask_special(model(in_a, in_b, in_op)));
          sent++;
        end
        @(posedge clk); #1;
        if (!did_rst && sent >= 5000 && out_valid) begin
          did_rst = 1;
          rst_n = 1'b0;
          #1 chk("reset_async_out_valid", out_valid, 1'b0);
          sbq.delete();
          in_valid = 1'b0;
          acc = 1;
          @(posedge clk); #1 rst_n = 1'b1;
        end
        if (acc || !in_valid) begin
          in_valid = (sent < 10000) && ($urandom_range(0, 3) != 0);
          in_a  = gen_a();
          in_b  = gen_b(in_a);
          in_op = 1'($urandom_range(0, 1));
        end
        out_ready = ($urandom_range(0, 3) != 0);
      end
      chk("rand_sent", sent, 10000);
      chk("rand_drained", sbq.size(), 0);
      chk("rand_reset_seen", {did_rst, first_post_chk}, 2'b11);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
